mem_scan_reader: RTL and testbench
==================================

# mem_scan_reader

Read-side sequencer for the small synchronous scratch RAM (2^ADDR_WIDTH words of DATA_WIDTH bits) that the board's switch interface writes. On a start request it walks every address in order and issues one read per word. It captures each returned word and holds it on the LED outputs for a programmable number of cycles. It also accumulates a checksum of all words, so the RAM contents can be checked on the board without touching the switches.

## Interface
- ADDR_WIDTH, 2, RAM address width; the scan covers addresses 0 .. 2^ADDR_WIDTH-1
- DATA_WIDTH, 4, RAM word width
- HOLD_CYCLES, 4, cycles each captured word is presented with dout_valid=1; legal range is 1 and up

- clk_2  in  1  system clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  scan request, sampled only in IDLE
- mem_wr  in  1  RAM write enable from the write side; a read cannot complete while it is high
- rd_en  out  1  read strobe to the RAM
- addr  out  ADDR_WIDTH  RAM read address
- rdata  in  DATA_WIDTH  RAM read data, valid the cycle after an accepted rd_en
- dout  out  DATA_WIDTH  last captured word
- dout_addr  out  ADDR_WIDTH  address of dout
- dout_valid  out  1  high while dout is being presented
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at the end of a scan
- sum  out  DATA_WIDTH+ADDR_WIDTH  running sum of the words read in the current or last scan

## Operation
- States: IDLE, ISSUE, WAIT, HOLD, DONE.
- IDLE:
  - When start=1, go to ISSUE, clear addr to 0 and clear sum to 0.
  - Otherwise stay in IDLE. sum, dout and dout_addr keep their last values.
- ISSUE:
  - rd_en = ~mem_wr, driven combinationally.
  - If mem_wr=0, go to WAIT. If mem_wr=1, stay in ISSUE with addr unchanged and retry the next cycle.
- WAIT:
  - Capture dout<=rdata and dout_addr<=addr.
  - Update sum<=sum+rdata, zero-extending rdata to the width of sum.
  - Load the hold counter with HOLD_CYCLES-1, then go to HOLD.
- HOLD:
  - dout_valid=1.
  - Decrement the hold counter each cycle. When it reaches 0:
    - if addr is all ones, go to DONE;
    - otherwise set addr<=addr+1 and go to ISSUE.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- Start requests in any state other than IDLE are ignored; they are not queued.
- sum cannot overflow, since 2^ADDR_WIDTH*(2^DATA_WIDTH-1) is less than 2^(DATA_WIDTH+ADDR_WIDTH). addr never wraps during a scan.
- Reset values: state=IDLE, and rd_en, addr, dout, dout_addr, dout_valid, busy, done and sum are all 0.
- A reset asserted mid-scan takes effect on that edge and abandons the scan; no done pulse is produced.

## Timing
- start is high in cycle 0. rd_en for address 0 is high in cycle 1 and busy is high from cycle 1.
- Read latency: an accepted rd_en in cycle N gives rdata in cycle N+1. dout updates and dout_valid rises in cycle N+2.
- Per word, with no write stalls: HOLD_CYCLES+2 cycles. dout_valid is high for exactly HOLD_CYCLES cycles per word and low in ISSUE and WAIT.
- Whole scan with no stalls: done is high in cycle 1+2^ADDR_WIDTH*(HOLD_CYCLES+2). With the defaults that is cycle 25, and the machine is in IDLE with busy=0 in cycle 26.
- Each cycle of mem_wr=1 while in ISSUE adds exactly one cycle. mem_wr in any other state has no effect on the reader.
- start held high continuously: a new scan begins in the cycle after IDLE is re-entered, which is the cycle after done.

## Test plan
- Reset and idle: hold reset for 2 cycles with start=0 -> all outputs 0, busy stays 0 for 10 cycles.
- Basic scan with defaults: preload RAM with 3,A,5,F and pulse start in cycle 0 ->
  - rd_en in cycles 1, 7, 13, 19;
  - dout/dout_addr = 3/0, A/1, 5/2, F/3, each with dout_valid high for 4 cycles starting in cycles 3, 9, 15, 21;
  - done in cycle 25 and sum = 0x21.
- Write stall: hold mem_wr=1 during cycles 7-9 ->
  - rd_en stays low in cycles 7-9 with addr=1, rd_en is high in cycle 10;
  - done moves to cycle 28;
  - the word read at address 1 is the value present after the write.
- Start ignored: pulse start in cycle 5 and again in cycle 20 during a scan -> a single done in cycle 25 and no restart.
- Reset mid-scan: assert reset in cycle 12 -> cycle 13 is IDLE with all outputs 0 and no done pulse. A fresh start then produces the same cycle sequence as the basic scan.
- Parameter corner: HOLD_CYCLES=1, ADDR_WIDTH=2, RAM all F -> dout_valid high for 1 cycle per word, done in cycle 13, sum = 0x3C.

Source files
------------

// File: rtl/mem_scan_reader.sv
// mem_scan_reader
//   Read-side sequencer for the scratch RAM. A start request walks every
//   address from 0 to 2^ADDR_WIDTH-1. For each address it issues one read,
//   captures the returned word and presents it on dout for HOLD_CYCLES
//   cycles. It also keeps a running checksum of every word read.
//
// Ports
//   clk_2       in   system clock, rising edge
//   reset       in   synchronous active-high reset
//   start       in   scan request, only honoured when idle
//   mem_wr      in   write-side strobe; a read is held off while it is high
//   rd_en       out  RAM read strobe
//   addr        out  RAM read address
//   rdata       in   RAM read data, one cycle after an accepted rd_en
//   dout        out  last captured word
//   dout_addr   out  address dout was read from
//   dout_valid  out  high while dout is being presented
//   busy        out  high whenever a scan is in progress
//   done        out  single-cycle pulse at the end of a scan
//   sum         out  sum of the words read in the current or last scan
module mem_scan_reader #(
  parameter int ADDR_WIDTH  = 2,
  parameter int DATA_WIDTH  = 4,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                             clk_2,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             mem_wr,
  output logic                             rd_en,
  output logic [ADDR_WIDTH-1:0]            addr,
  input  logic [DATA_WIDTH-1:0]            rdata,
  output logic [DATA_WIDTH-1:0]            dout,
  output logic [ADDR_WIDTH-1:0]            dout_addr,
  output logic                             dout_valid,
  output logic                             busy,
  output logic                             done,
  output logic [DATA_WIDTH+ADDR_WIDTH-1:0] sum
);

  localparam int SUM_W = DATA_WIDTH + ADDR_WIDTH;
  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HOLD,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   dout_q, dout_d;
  logic [ADDR_WIDTH-1:0]   dout_addr_q, dout_addr_d;
  logic [SUM_W-1:0]        sum_q, sum_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  // Checksum accumulate: the word is zero-extended; the sum is wide enough
  // that a full scan of all-ones words cannot overflow.
  function automatic logic [SUM_W-1:0] acc_add(input logic [SUM_W-1:0]      acc,
                                               input logic [DATA_WIDTH-1:0] w);
    return acc + SUM_W'(w);
  endfunction

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    dout_d      = dout_q;
    dout_addr_d = dout_addr_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    rd_en       = 1'b0;
    dout_valid  = 1'b0;
    done        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ISSUE;
          addr_d  = '0;
          sum_d   = '0;
        end
      end

      // A write on the shared RAM blocks the read; retry the same address.
      S_ISSUE: begin
        rd_en = ~mem_wr;
        if (!mem_wr) begin
          state_d = S_WAIT;
        end
      end

      // Read data arrives this cycle.
      S_WAIT: begin
        dout_d      = rdata;
        dout_addr_d = addr_q;
        sum_d       = acc_add(sum_q, rdata);
        cnt_d       = HOLD_LOAD;
        state_d     = S_HOLD;
      end

      S_HOLD: begin
        dout_valid = 1'b1;
        if (cnt_q == '0) begin
          if (&addr_q) begin
            state_d = S_DONE;
          end else begin
            addr_d  = addr_q + ADDR_WIDTH'(1);
            state_d = S_ISSUE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      dout_q      <= '0;
      dout_addr_q <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      dout_q      <= dout_d;
      dout_addr_q <= dout_addr_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign addr      = addr_q;
  assign dout      = dout_q;
  assign dout_addr = dout_addr_q;
  assign sum       = sum_q;

endmodule

// File: tb/tb_mem_scan_reader.sv
// Testbench for mem_scan_reader: default-parameter instance with a small
// RAM model, plus a HOLD_CYCLES=1 instance reading an all-F RAM.
module tb_mem_scan_reader;

  logic clk_2 = 1'b0;
  always #5 clk_2 = ~clk_2;

  logic       reset, start, mem_wr;
  logic       rd_en, dout_valid, busy, done;
  logic [1:0] addr, dout_addr, wr_addr;
  logic [3:0] rdata, dout, wr_data;
  logic [5:0] sum;

  logic       start1, mem_wr1;
  logic       rd_en1, dout_valid1, busy1, done1;
  logic [1:0] addr1, dout_addr1;
  logic [3:0] rdata1, dout1;
  logic [5:0] sum1;

  logic [3:0] ram [4];

  int n_chk = 0;
  int n_err = 0;

  mem_scan_reader #(.ADDR_WIDTH(2), .DATA_WIDTH(4), .HOLD_CYCLES(4)) dut (
    .clk_2(clk_2), .reset(reset), .start(start), .mem_wr(mem_wr),
    .rd_en(rd_en), .addr(addr), .rdata(rdata), .dout(dout),
    .dout_addr(dout_addr), .dout_valid(dout_valid), .busy(busy),
    .done(done), .sum(sum)
  );

  mem_scan_reader #(.ADDR_WIDTH(2), .DATA_WIDTH(4), .HOLD_CYCLES(1)) dut_h1 (
    .clk_2(clk_2), .reset(reset), .start(start1), .mem_wr(mem_wr1),
    .rd_en(rd_en1), .addr(addr1), .rdata(rdata1), .dout(dout1),
    .dout_addr(dout_addr1), .dout_valid(dout_valid1), .busy(busy1),
    .done(done1), .sum(sum1)
  );

  // Synchronous RAM: registered read, write port from the bench.
  always @(posedge clk_2) begin
    if (mem_wr) ram[wr_addr] <= wr_data;
    if (rd_en)  rdata <= ram[addr];
  end

  always @(posedge clk_2) begin
    if (rd_en1) rdata1 <= 4'hF;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_2);
    #1;
  endtask

  task automatic ram_wr(input logic [1:0] a, input logic [3:0] d);
    wr_addr = a;
    wr_data = d;
    mem_wr  = 1'b1;
    tick();
    mem_wr  = 1'b0;
  endtask

  // Called just after a rising edge; that cycle is cycle 0 of the scan.
  // stall: mem_wr high in cycles 7-9 (writes wr_data to wr_addr).
  // ign:   extra start pulses in cycles 5 and 20.
  task automatic scan_run(input bit stall, input logic [3:0] w1, input bit ign,
                          input logic [5:0] exp_sum);
    logic [3:0] exp_w [4];
    int         done_c;
    int         off;
    int         kv;
    logic       exp_rd, exp_v;
    exp_w  = '{4'h3, w1, 4'h5, 4'hF};
    done_c = stall ? 28 : 25;
    for (int c = 0; c <= done_c + 3; c++) begin
      start  = (c == 0) || (ign && (c == 5 || c == 20));
      mem_wr = stall && (c >= 7) && (c <= 9);
      @(negedge clk_2);
      exp_rd = 1'b0;
      exp_v  = 1'b0;
      kv     = -1;
      for (int k = 0; k < 4; k++) begin
        off = (stall && k >= 1) ? 3 : 0;
        if (c == 1 + 6 * k + off) exp_rd = 1'b1;
        if (c >= 3 + 6 * k + off && c <= 6 + 6 * k + off) begin
          exp_v = 1'b1;
          kv    = k;
        end
      end
      chk("rd_en", 32'(rd_en), 32'(exp_rd));
      chk("dout_valid", 32'(dout_valid), 32'(exp_v));
      chk("done", 32'(done), 32'(c == done_c));
      chk("busy", 32'(busy), 32'(c >= 1 && c <= done_c));
      if (kv >= 0) begin
        chk("dout", 32'(dout), 32'(exp_w[kv]));
        chk("dout_addr", 32'(dout_addr), 32'(kv));
      end
      if (stall && c >= 7 && c <= 9) chk("stall_addr", 32'(addr), 32'd1);
      if (c == done_c) chk("sum", 32'(sum), 32'(exp_sum));
      tick();
    end
    start  = 1'b0;
    mem_wr = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    mem_wr  = 1'b0;
    wr_addr = 2'd0;
    wr_data = 4'd0;
    start1  = 1'b0;
    mem_wr1 = 1'b0;

    // Reset for two cycles, then idle.
    tick();
    tick();
    reset = 1'b0;
    @(negedge clk_2);
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_dout_addr", 32'(dout_addr), 32'd0);
    chk("rst_dout_valid", 32'(dout_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_h1_busy", 32'(busy1), 32'd0);
    for (int i = 0; i < 10; i++) begin
      chk("idle_busy", 32'(busy), 32'd0);
      tick();
      @(negedge clk_2);
    end
    tick();

    // Preload 3, A, 5, F through the write port while the reader idles.
    ram_wr(2'd0, 4'h3);
    ram_wr(2'd1, 4'hA);
    ram_wr(2'd2, 4'h5);
    ram_wr(2'd3, 4'hF);

    // Basic scan.
    scan_run(1'b0, 4'hA, 1'b0, 6'h21);

    // Start pulses during a scan are ignored.
    scan_run(1'b0, 4'hA, 1'b1, 6'h21);

    // Reset mid-scan at cycle 12.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (11) tick();
    reset = 1'b1;
    @(negedge clk_2);
    chk("mid_busy12", 32'(busy), 32'd1);
    tick();
    reset = 1'b0;
    @(negedge clk_2);
    chk("mid_busy13", 32'(busy), 32'd0);
    chk("mid_rd_en", 32'(rd_en), 32'd0);
    chk("mid_addr", 32'(addr), 32'd0);
    chk("mid_dout", 32'(dout), 32'd0);
    chk("mid_dout_addr", 32'(dout_addr), 32'd0);
    chk("mid_dout_valid", 32'(dout_valid), 32'd0);
    chk("mid_sum", 32'(sum), 32'd0);
    for (int i = 0; i < 15; i++) begin
      chk("mid_no_done", 32'(done), 32'd0);
      chk("mid_idle", 32'(busy), 32'd0);
      tick();
      @(negedge clk_2);
    end
    tick();
    scan_run(1'b0, 4'hA, 1'b0, 6'h21);

    // Write stall in cycles 7-9 writes 6 to address 1 before it is read.
    wr_addr = 2'd1;
    wr_data = 4'h6;
    scan_run(1'b1, 4'h6, 1'b0, 6'h1D);
    ram_wr(2'd1, 4'hA);

    // Start held high: new scan starts the cycle after IDLE is re-entered.
    for (int c = 0; c <= 27; c++) begin
      start = 1'b1;
      @(negedge clk_2);
      if (c == 25) chk("held_done25", 32'(done), 32'd1);
      if (c == 26) chk("held_idle26", 32'(busy), 32'd0);
      if (c == 27) begin
        chk("held_rd_en27", 32'(rd_en), 32'd1);
        chk("held_addr27", 32'(addr), 32'd0);
        chk("held_sum27", 32'(sum), 32'd0);
      end
      tick();
    end
    start = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;

    // HOLD_CYCLES=1 instance, RAM all F.
    for (int c = 0; c <= 16; c++) begin
      start1 = (c == 0);
      @(negedge clk_2);
      chk("h1_rd_en", 32'(rd_en1), 32'(c >= 1 && c <= 10 && ((c - 1) % 3 == 0)));
      chk("h1_dout_valid", 32'(dout_valid1), 32'(c >= 3 && c <= 12 && (c % 3 == 0)));
      chk("h1_done", 32'(done1), 32'(c == 13));
      chk("h1_busy", 32'(busy1), 32'(c >= 1 && c <= 13));
      if (c >= 3 && c <= 12 && (c % 3 == 0)) begin
        chk("h1_dout", 32'(dout1), 32'hF);
        chk("h1_dout_addr", 32'(dout_addr1), 32'((c - 3) / 3));
      end
      if (c == 13) chk("h1_sum", 32'(sum1), 32'h3C);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
